// File: rtl/lc3b_types_pkg.sv
// Shared LC-3b pipeline types used by the MEM stage.
package lc3b_types;

  // MEM-stage sequencing: idle, first/direct access, second access of LDI/STI.
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ACCESS   = 2'd1,
    INDIRECT = 2'd2
  } mem_state_t;

  // Byte lanes in a 16-bit LC-3b memory word.
  localparam int LC3B_BYTE_LANES = 2;

  // Write-back control bundle carried through MEM unchanged.
  localparam int LC3B_WB_CS_WIDTH = 4;
  typedef logic [LC3B_WB_CS_WIDTH-1:0] lc3b_wb_cs;

endpackage

// File: rtl/mem_access_unit_byte_align.sv
// Byte-lane steering for the MEM stage: load lane select with sign extension,
// store byte replication and byte-enable generation. Purely combinational.
module mem_byte_align #(
  parameter int DATA_WIDTH = 16,
  parameter int LANES      = DATA_WIDTH / 8,
  parameter int LANE_W     = (LANES > 1) ? $clog2(LANES) : 1
) (
  input  logic [LANE_W-1:0]     lane,
  input  logic                  is_byte,
  input  logic                  is_write,
  input  logic [DATA_WIDTH-1:0] store_word,
  input  logic [DATA_WIDTH-1:0] rdata,
  output logic [DATA_WIDTH-1:0] load_data,
  output logic [DATA_WIDTH-1:0] wdata,
  output logic [LANES-1:0]      byte_enable
);

  logic [7:0] lane_byte;

  // Pick the addressed lane out of the read word and format the load result.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    lane_byte = '0;
    for (int i = 0; i < LANES; i++) begin
      if (lane == LANE_W'(i)) lane_byte = rdata[8*i +: 8];
    end
    load_data = is_byte ? {{(DATA_WIDTH-8){lane_byte[7]}}, lane_byte} : rdata;
  end

  // Byte stores put the low byte on every lane and enable only the addressed one.
  always_comb begin
    wdata       = is_byte ? {LANES{store_word[7:0]}} : store_word;
    byte_enable = (is_byte && is_write) ? (LANES'(1) << lane) : {LANES{1'b1}};
  end

endmodule

// File: rtl/mem_access_unit.sv
// LC-3b MEM stage: sequences direct, byte and indirect memory accesses over a
// request/response port, stalls upstream meanwhile, and owns the MEM/WB register.
module mem_access_unit
  import lc3b_types::*;
#(
  parameter int DATA_WIDTH  = 16,
  parameter int ADDR_WIDTH  = 16,
  parameter int WB_CS_WIDTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic [ADDR_WIDTH-1:0]   in_address,
  input  logic                    in_op_read,
  input  logic                    in_op_write,
  input  logic                    in_op_indirect,
  input  logic                    in_op_byte,
  input  logic [WB_CS_WIDTH-1:0]  in_wb_cs,
  input  logic [DATA_WIDTH-1:0]   in_npc,
  input  logic [DATA_WIDTH-1:0]   in_aluresult,
  input  logic [DATA_WIDTH-1:0]   in_ir,
  input  logic [2:0]              in_cc,
  input  logic [2:0]              in_drid,
  output logic                    stall_out,
  output logic                    out_valid,
  output logic [ADDR_WIDTH-1:0]   out_address,
  output logic [DATA_WIDTH-1:0]   out_data,
  output logic [WB_CS_WIDTH-1:0]  out_wb_cs,
  output logic [DATA_WIDTH-1:0]   out_npc,
  output logic [DATA_WIDTH-1:0]   out_aluresult,
  output logic [DATA_WIDTH-1:0]   out_ir,
  output logic [2:0]              out_cc,
  output logic [2:0]              out_drid,
  output logic                    mem_read,
  output logic                    mem_write,
  output logic [ADDR_WIDTH-1:0]   mem_address,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  output logic [DATA_WIDTH/8-1:0] mem_byte_enable,
  input  logic [DATA_WIDTH-1:0]   mem_rdata,
  input  logic                    mem_resp
);

  localparam int LANES  = DATA_WIDTH / 8;
  localparam int LANE_W = $clog2(LANES);

  mem_state_t state;
  logic       ptr_phase;   // ACCESS is fetching the LDI/STI pointer

  // EX/MEM fields captured when a memory op is accepted.
  logic [ADDR_WIDTH-1:0]  lat_address;
  logic [ADDR_WIDTH-1:0]  lat_pointer;
  logic                   lat_write;
  logic                   lat_byte;
  logic [WB_CS_WIDTH-1:0] lat_wb_cs;
  logic [DATA_WIDTH-1:0]  lat_npc;
  logic [DATA_WIDTH-1:0]  lat_aluresult;
  logic [DATA_WIDTH-1:0]  lat_ir;
  logic [2:0]             lat_cc;
  logic [2:0]             lat_drid;

  logic                  ptr_access;
  logic                  final_access;
  logic [ADDR_WIDTH-1:0] acc_address;
  logic [DATA_WIDTH-1:0] align_load;
  logic [DATA_WIDTH-1:0] align_wdata;
  logic [LANES-1:0]      align_be;

  wire mem_op = in_op_read | in_op_write;

  // Classify the access in flight and choose its effective address.
  always_comb begin
    ptr_access   = (state == ACCESS) && ptr_phase;
    final_access = ((state == ACCESS) && !ptr_phase) || (state == INDIRECT);
    acc_address  = (state == INDIRECT) ? lat_pointer : lat_address;
  end

  assign stall_out       = (state != IDLE);
  assign mem_read        = ptr_access || (final_access && !lat_write);
  assign mem_write       = final_access && lat_write;
  assign mem_address     = stall_out ? {acc_address[ADDR_WIDTH-1:LANE_W], {LANE_W{1'b0}}} : '0;
  assign mem_wdata       = mem_write ? align_wdata : '0;
  assign mem_byte_enable = stall_out ? align_be : '0;

  // The pointer fetch is always a full-word read, so byte steering applies only
  // to the final access.
  mem_byte_align #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_align (
    .lane        (acc_address[LANE_W-1:0]),
    .is_byte     (final_access && lat_byte),
    .is_write    (lat_write),
    .store_word  (lat_aluresult),
    .rdata       (mem_rdata),
    .load_data   (align_load),
    .wdata       (align_wdata),
    .byte_enable (align_be)
  );

  // Access sequencer plus the MEM/WB register it loads.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: synchronous reset clears all state here; there is no memory array,
      // so every register can be reset, which also aborts any access in flight.
      state         <= IDLE;
      ptr_phase     <= 1'b0;
      lat_address   <= '0;
      lat_pointer   <= '0;
      lat_write     <= 1'b0;
      lat_byte      <= 1'b0;
      lat_wb_cs     <= '0;
      lat_npc       <= '0;
      lat_aluresult <= '0;
      lat_ir        <= '0;
      lat_cc        <= '0;
      lat_drid      <= '0;
      out_valid     <= 1'b0;
      out_address   <= '0;
      out_data      <= '0;
      out_wb_cs     <= '0;
      out_npc       <= '0;
      out_aluresult <= '0;
      out_ir        <= '0;
      out_cc        <= '0;
      out_drid      <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every register update in this block
      // based on pre-edge values, regardless of statement order.
      out_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid && mem_op) begin
            lat_address   <= in_address;
            lat_write     <= in_op_write;
            lat_byte      <= in_op_byte;
            lat_wb_cs     <= in_wb_cs;
            lat_npc       <= in_npc;
            lat_aluresult <= in_aluresult;
            lat_ir        <= in_ir;
            lat_cc        <= in_cc;
            lat_drid      <= in_drid;
            ptr_phase     <= in_op_indirect;
            state         <= ACCESS;
          end else if (in_valid) begin
            out_valid     <= 1'b1;
            out_address   <= in_address;
            out_data      <= '0;
            out_wb_cs     <= in_wb_cs;
            out_npc       <= in_npc;
            out_aluresult <= in_aluresult;
            out_ir        <= in_ir;
            out_cc        <= in_cc;
            out_drid      <= in_drid;
          end
        end
        ACCESS, INDIRECT: begin
          if (mem_resp && ptr_access) begin
            lat_pointer <= ADDR_WIDTH'(mem_rdata);
            ptr_phase   <= 1'b0;
            state       <= INDIRECT;
          end else if (mem_resp) begin
            out_valid     <= 1'b1;
            out_address   <= acc_address;
            out_data      <= lat_write ? '0 : align_load;
            out_wb_cs     <= lat_wb_cs;
            out_npc       <= lat_npc;
            out_aluresult <= lat_aluresult;
            out_ir        <= lat_ir;
            out_cc        <= lat_cc;
            out_drid      <= lat_drid;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: ALU pass-through, word/byte loads and
// stores, indirect loads, and reset during an access.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [15:0] in_address;
  logic        in_op_read, in_op_write, in_op_indirect, in_op_byte;
  logic [3:0]  in_wb_cs;
  logic [15:0] in_npc, in_aluresult, in_ir;
  logic [2:0]  in_cc, in_drid;
  logic        stall_out, out_valid;
  logic [15:0] out_address, out_data;
  logic [3:0]  out_wb_cs;
  logic [15:0] out_npc, out_aluresult, out_ir;
  logic [2:0]  out_cc, out_drid;
  logic        mem_read, mem_write;
  logic [15:0] mem_address, mem_wdata;
  logic [1:0]  mem_byte_enable;
  logic [15:0] mem_rdata;
  logic        mem_resp;

  int passed = 0;
  int total  = 0;
  int hs_count = 0;

  // Values observed on the port in the cycle a response is given.
  logic [15:0] cap_addr, cap_wdata;
  logic [1:0]  cap_be;
  logic        cap_rd, cap_wr;

  always #5 clk = ~clk;

  mem_access_unit #(
    .DATA_WIDTH (16),
    .ADDR_WIDTH (16),
    .WB_CS_WIDTH(4)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_address(in_address),
    .in_op_read(in_op_read), .in_op_write(in_op_write),
    .in_op_indirect(in_op_indirect), .in_op_byte(in_op_byte),
    .in_wb_cs(in_wb_cs), .in_npc(in_npc), .in_aluresult(in_aluresult),
    .in_ir(in_ir), .in_cc(in_cc), .in_drid(in_drid),
    .stall_out(stall_out), .out_valid(out_valid), .out_address(out_address),
    .out_data(out_data), .out_wb_cs(out_wb_cs), .out_npc(out_npc),
    .out_aluresult(out_aluresult), .out_ir(out_ir), .out_cc(out_cc),
    .out_drid(out_drid),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_wdata(mem_wdata), .mem_byte_enable(mem_byte_enable),
    .mem_rdata(mem_rdata), .mem_resp(mem_resp)
  );

  // Completed handshakes on the memory port.
  always @(posedge clk) begin
    if (mem_resp && (mem_read || mem_write)) hs_count <= hs_count + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic clear_inputs();
    in_valid = 0; in_address = 0; in_op_read = 0; in_op_write = 0;
    in_op_indirect = 0; in_op_byte = 0; in_wb_cs = 0; in_npc = 0;
    in_aluresult = 0; in_ir = 0; in_cc = 0; in_drid = 0;
  endtask

  // Present one instruction for a single accepting edge, then clear EX/MEM.
  task automatic issue(input logic [15:0] addr, input logic rd, input logic wr,
                       input logic ind, input logic byt, input logic [15:0] alu,
                       input logic [2:0] drid);
    in_valid = 1; in_address = addr; in_op_read = rd; in_op_write = wr;
    in_op_indirect = ind; in_op_byte = byt; in_aluresult = alu; in_drid = drid;
    in_wb_cs = 4'h9; in_npc = addr + 16'd2; in_ir = 16'h6000; in_cc = 3'b001;
    @(posedge clk); #1;
    clear_inputs();
  endtask

  // Wait (bounded) for a request, hold it wait_cycles more, then answer it.
  task automatic respond(input logic [15:0] rdata, input int wait_cycles, output logic ok);
    int n = 0;
    while (!(mem_read || mem_write) && n < 20) begin
      @(posedge clk); #1; n++;
    end
    ok = mem_read || mem_write;
    repeat (wait_cycles) begin @(posedge clk); #1; end
    cap_addr = mem_address; cap_wdata = mem_wdata; cap_be = mem_byte_enable;
    cap_rd = mem_read; cap_wr = mem_write;
    mem_rdata = rdata; mem_resp = 1;
    @(posedge clk); #1;
    mem_resp = 0; mem_rdata = 16'h0;
  endtask

  task automatic test_reset();
    rst = 1; clear_inputs(); mem_rdata = 0; mem_resp = 0;
    repeat (2) @(posedge clk);
    #1;
    total++; if (stall_out !== 1'b0) $display("FAIL rst_stall: got %h expected 0", stall_out); else passed++;
    total++; if (out_valid !== 1'b0) $display("FAIL rst_valid: got %h expected 0", out_valid); else passed++;
    total++; if ({mem_read, mem_write, mem_byte_enable} !== 4'b0) $display("FAIL rst_strobes: got %h expected 0", {mem_read, mem_write, mem_byte_enable}); else passed++;
    total++; if ({out_data, out_aluresult, out_drid} !== 35'h0) $display("FAIL rst_memwb: got %h expected 0", {out_data, out_aluresult, out_drid}); else passed++;
    rst = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_alu_op();
    in_valid = 1; in_aluresult = 16'h1234; in_address = 16'h0BAD; in_drid = 3'd5;
    in_ir = 16'h1042; in_cc = 3'b010; in_wb_cs = 4'hA; in_npc = 16'h3002;
    total++; if (stall_out !== 1'b0) $display("FAIL add_stall_pre: got %h expected 0", stall_out); else passed++;
    @(posedge clk); #1;
    clear_inputs();
    total++; if (out_valid !== 1'b1) $display("FAIL add_valid: got %h expected 1", out_valid); else passed++;
    total++; if (out_aluresult !== 16'h1234) $display("FAIL add_alu: got %h expected 1234", out_aluresult); else passed++;
    total++; if (out_data !== 16'h0) $display("FAIL add_data: got %h expected 0", out_data); else passed++;
    total++; if ({out_drid, out_cc, out_wb_cs, out_ir, out_npc, out_address} !== {3'd5, 3'b010, 4'hA, 16'h1042, 16'h3002, 16'h0BAD})
      $display("FAIL add_passthru: got %h expected %h", {out_drid, out_cc, out_wb_cs, out_ir, out_npc, out_address},
               {3'd5, 3'b010, 4'hA, 16'h1042, 16'h3002, 16'h0BAD}); else passed++;
    total++; if ({mem_read, mem_write, stall_out} !== 3'b0) $display("FAIL add_no_mem: got %h expected 0", {mem_read, mem_write, stall_out}); else passed++;
    @(posedge clk); #1;
    total++; if (out_valid !== 1'b0) $display("FAIL add_pulse: got %h expected 0", out_valid); else passed++;
  endtask

  task automatic test_ldr();
    int stall_cnt = 0;
    issue(16'h3001, 1, 0, 0, 0, 16'h0, 3'd2);
    for (int c = 1; c <= 3; c++) begin
      if (stall_out) stall_cnt++;
      if (c == 1) begin
        total++; if ({mem_read, mem_write} !== 2'b10) $display("FAIL ldr_strobe: got %b expected 10", {mem_read, mem_write}); else passed++;
        total++; if (mem_address !== 16'h3000) $display("FAIL ldr_addr: got %h expected 3000", mem_address); else passed++;
        total++; if (mem_byte_enable !== 2'b11) $display("FAIL ldr_be: got %b expected 11", mem_byte_enable); else passed++;
      end
      if (c == 3) begin mem_rdata = 16'hBEEF; mem_resp = 1; end
      @(posedge clk); #1;
    end
    mem_resp = 0; mem_rdata = 0;
    total++; if (stall_cnt !== 3) $display("FAIL ldr_stall_cycles: got %0d expected 3", stall_cnt); else passed++;
    total++; if ({stall_out, out_valid} !== 2'b01) $display("FAIL ldr_done: got %b expected 01", {stall_out, out_valid}); else passed++;
    total++; if (out_data !== 16'hBEEF) $display("FAIL ldr_data: got %h expected beef", out_data); else passed++;
    total++; if (out_drid !== 3'd2) $display("FAIL ldr_drid: got %h expected 2", out_drid); else passed++;
    @(posedge clk); #1;
    total++; if (out_valid !== 1'b0) $display("FAIL ldr_pulse: got %h expected 0", out_valid); else passed++;
  endtask

  task automatic test_byte_load(input logic [15:0] addr, input logic [15:0] rdata, input logic [15:0] exp);
    logic ok;
    issue(addr, 1, 0, 0, 1, 16'h0, 3'd1);
    respond(rdata, 1, ok);
    total++; if (ok !== 1'b1) $display("FAIL ldb_req_timeout: got %h expected 1", ok); else passed++;
    total++; if ({cap_rd, cap_wr, cap_be} !== 4'b1011) $display("FAIL ldb_req: got %b expected 1011", {cap_rd, cap_wr, cap_be}); else passed++;
    total++; if ({out_valid, out_data} !== {1'b1, exp}) $display("FAIL ldb_data: got %h expected %h", {out_valid, out_data}, {1'b1, exp}); else passed++;
  endtask

  task automatic test_stores();
    logic ok;
    // Byte store to the upper lane.
    issue(16'h4001, 0, 1, 0, 1, 16'h0055, 3'd0);
    respond(16'hFFFF, 0, ok);
    total++; if (ok !== 1'b1) $display("FAIL stb_req_timeout: got %h expected 1", ok); else passed++;
    total++; if ({cap_rd, cap_wr} !== 2'b01) $display("FAIL stb_strobe: got %b expected 01", {cap_rd, cap_wr}); else passed++;
    total++; if (cap_wdata !== 16'h5555) $display("FAIL stb_wdata: got %h expected 5555", cap_wdata); else passed++;
    total++; if (cap_be !== 2'b10) $display("FAIL stb_be: got %b expected 10", cap_be); else passed++;
    total++; if (cap_addr !== 16'h4000) $display("FAIL stb_addr: got %h expected 4000", cap_addr); else passed++;
    total++; if ({out_valid, out_data} !== 17'h10000) $display("FAIL stb_out: got %h expected 10000", {out_valid, out_data}); else passed++;
    // Word store with read also set: write wins.
    issue(16'h4002, 1, 1, 0, 0, 16'hA5C3, 3'd0);
    respond(16'h1357, 2, ok);
    total++; if ({cap_rd, cap_wr} !== 2'b01) $display("FAIL str_rw_write_wins: got %b expected 01", {cap_rd, cap_wr}); else passed++;
    total++; if ({cap_wdata, cap_be} !== {16'hA5C3, 2'b11}) $display("FAIL str_wdata_be: got %h expected %h", {cap_wdata, cap_be}, {16'hA5C3, 2'b11}); else passed++;
    total++; if ({out_valid, out_data} !== 17'h10000) $display("FAIL str_out: got %h expected 10000", {out_valid, out_data}); else passed++;
  endtask

  task automatic test_ldi();
    logic ok;
    int base;
    base = hs_count;
    issue(16'h5000, 1, 0, 1, 0, 16'h0, 3'd7);
    respond(16'h6000, 0, ok);
    total++; if ({ok, cap_rd, cap_addr} !== {2'b11, 16'h5000}) $display("FAIL ldi_ptr_req: got %h expected %h", {ok, cap_rd, cap_addr}, {2'b11, 16'h5000}); else passed++;
    total++; if ({stall_out, out_valid, mem_read, mem_address} !== {3'b101, 16'h6000})
      $display("FAIL ldi_second_req: got %h expected %h", {stall_out, out_valid, mem_read, mem_address}, {3'b101, 16'h6000}); else passed++;
    respond(16'h0042, 1, ok);
    total++; if ({out_valid, out_data} !== {1'b1, 16'h0042}) $display("FAIL ldi_data: got %h expected %h", {out_valid, out_data}, {1'b1, 16'h0042}); else passed++;
    total++; if (out_address !== 16'h6000) $display("FAIL ldi_out_addr: got %h expected 6000", out_address); else passed++;
    total++; if (hs_count - base !== 2) $display("FAIL ldi_handshakes: got %0d expected 2", hs_count - base); else passed++;
  endtask

  task automatic test_reset_mid_access();
    int base;
    base = hs_count;
    issue(16'h7000, 1, 0, 0, 0, 16'h0, 3'd3);
    total++; if (mem_read !== 1'b1) $display("FAIL abort_pre_req: got %h expected 1", mem_read); else passed++;
    rst = 1;
    @(posedge clk); #1;
    rst = 0; mem_rdata = 16'h1111; mem_resp = 1;
    total++; if ({mem_read, mem_write, stall_out, out_valid} !== 4'b0) $display("FAIL abort_strobes: got %b expected 0000", {mem_read, mem_write, stall_out, out_valid}); else passed++;
    @(posedge clk); #1;
    mem_resp = 0; mem_rdata = 0;
    total++; if ({stall_out, out_valid, out_data} !== 18'h0) $display("FAIL abort_late_resp: got %h expected 0", {stall_out, out_valid, out_data}); else passed++;
    total++; if (hs_count !== base) $display("FAIL abort_handshakes: got %0d expected %0d", hs_count, base); else passed++;
  endtask

  initial begin
    test_reset();
    test_alu_op();
    test_ldr();
    test_byte_load(16'h3001, 16'h80AA, 16'hFF80);
    test_byte_load(16'h3000, 16'h80AA, 16'hFFAA);
    test_stores();
    test_ldi();
    test_reset_mid_access();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
